// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter for the Tomasulo common data bus
// One holding slot per FU; at most one registered broadcast per cycle.
module cdb_arbiter #(
  parameter int N_SRC  = 4,
  parameter int SRC_W  = 2,
  parameter int TAG_W  = 15,
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [N_SRC-1:0]        req_valid,
  input  logic [N_SRC*TAG_W-1:0]  req_tag,
  input  logic [N_SRC*DATA_W-1:0] req_data,
  output logic [N_SRC-1:0]        req_ready,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic [SRC_W-1:0]        cdb_src,
  output logic [SRC_W:0]          occ
);

  logic [N_SRC-1:0]  slot_v;
  logic [TAG_W-1:0]  slot_tag  [N_SRC];
  logic [DATA_W-1:0] slot_data [N_SRC];
  logic [SRC_W-1:0]  rr_ptr;

  logic              blocked;
  logic [N_SRC-1:0]  grant;
  logic [N_SRC-1:0]  accept;
  logic [N_SRC-1:0]  slot_v_nxt;
  logic              grant_any;
  logic [SRC_W-1:0]  grant_idx;
  logic [SRC_W:0]    occ_nxt;

  assign blocked = flush | reset;

  // Scan from rr_ptr upward, wrapping at N_SRC (not 2^SRC_W).
  always_comb begin
    int k;
    k         = 0;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int j = 0; j < N_SRC; j++) begin
      k = int'(rr_ptr) + j;
      if (k >= N_SRC) k = k - N_SRC;
      if (!blocked && !grant_any && slot_v[k]) begin
        grant_any = 1'b1;
        grant_idx = SRC_W'(k);
        grant[k]  = 1'b1;
      end
    end
  end

  // A slot being drained this cycle can be refilled in the same cycle.
  assign req_ready  = ~{N_SRC{blocked}} & (~slot_v | grant);
  assign accept     = req_valid & req_ready;
  assign slot_v_nxt = blocked ? '0 : ((slot_v & ~grant) | accept);

  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < N_SRC; i++) begin
      occ_nxt = occ_nxt + {{SRC_W{1'b0}}, slot_v_nxt[i]};
    end
  end

  always_ff @(posedge clk) begin
    slot_v <= slot_v_nxt;
    occ    <= occ_nxt;
    for (int i = 0; i < N_SRC; i++) begin
      if (accept[i]) begin
        slot_tag[i]  <= req_tag[i*TAG_W +: TAG_W];
        slot_data[i] <= req_data[i*DATA_W +: DATA_W];
      end
    end
    if (reset) begin
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else if (grant_any) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= slot_tag[grant_idx];
      cdb_data  <= slot_data[grant_idx];
      cdb_src   <= grant_idx;
      rr_ptr    <= (int'(grant_idx) == N_SRC - 1) ? '0 : grant_idx + SRC_W'(1);
    end else begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter
// Stimulus pushes hand-computed broadcasts; a negedge monitor pops and compares.
module tb_cdb_arbiter;
  localparam int N_SRC  = 4;
  localparam int SRC_W  = 2;
  localparam int TAG_W  = 15;
  localparam int DATA_W = 16;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    flush;
  logic [N_SRC-1:0]        req_valid;
  logic [N_SRC*TAG_W-1:0]  req_tag;
  logic [N_SRC*DATA_W-1:0] req_data;
  logic [N_SRC-1:0]        req_ready;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_data;
  logic [SRC_W-1:0]        cdb_src;
  logic [SRC_W:0]          occ;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [SRC_W-1:0]  src;
  } bc_t;

  bc_t exp_q[$];
  bc_t mon_e;
  int  n_cmp = 0;
  int  n_bad = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.N_SRC(N_SRC), .SRC_W(SRC_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data), .req_ready(req_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src),
    .occ(occ)
  );

  always @(negedge clk) begin
    if (cdb_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL cdb_unexpected: got tag=%0d data=%h src=%0d, required no broadcast",
                 cdb_tag, cdb_data, cdb_src);
      end else begin
        mon_e = exp_q.pop_front();
        if (cdb_tag !== mon_e.tag || cdb_data !== mon_e.data || cdb_src !== mon_e.src) begin
          n_bad++;
          $display("FAIL cdb_bcast: got tag=%0d data=%h src=%0d, required tag=%0d data=%h src=%0d",
                   cdb_tag, cdb_data, cdb_src, mon_e.tag, mon_e.data, mon_e.src);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic clear_req();
    req_valid = '0;
    req_tag   = '0;
    req_data  = '0;
  endtask

  task automatic set_req(input int i, input int t, input int d);
    req_valid[i]                   = 1'b1;
    req_tag[i*TAG_W +: TAG_W]      = TAG_W'(t);
    req_data[i*DATA_W +: DATA_W]   = DATA_W'(d);
  endtask

  task automatic expect_bc(input int t, input int d, input int s);
    bc_t e;
    e.tag  = TAG_W'(t);
    e.data = DATA_W'(d);
    e.src  = SRC_W'(s);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    clear_req();
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    tick();
  endtask

  int unsigned ft[6] = '{20, 21, 22, 22, 23, 24};
  int unsigned fr[6] = '{1, 1, 0, 1, 1, 1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_cdb_valid", 32'(cdb_valid), 0);
    check("rst_cdb_tag",   32'(cdb_tag),   0);
    check("rst_cdb_data",  32'(cdb_data),  0);
    check("rst_cdb_src",   32'(cdb_src),   0);
    check("rst_occ",       32'(occ),       0);
    check("rst_req_ready", 32'(req_ready), 32'hF);

    // Single source: latency then one result per cycle
    clear_req();
    set_req(1, 3, 16'hBEEF);
    expect_bc(3, 16'hBEEF, 1);
    #1 check("single_ready_k", 32'(req_ready[1]), 1);
    tick();
    check("single_latency", 32'(cdb_valid), 0);
    for (int t = 4; t <= 6; t++) begin
      clear_req();
      set_req(1, t, 16'h0100 + t);
      expect_bc(t, 16'h0100 + t, 1);
      #1 check("stream_ready1", 32'(req_ready[1]), 1);
      tick();
    end
    clear_req();
    drain();

    // Contention from rr_ptr=0, no further pushes
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(i, 10 + i, 16'h1000 + 10 + i);
      expect_bc(10 + i, 16'h1000 + 10 + i, i);
    end
    tick();
    clear_req();
    #1;
    for (int c = 0; c < 5; c++) begin
      check("cont_occ", 32'(occ), 32'(4 - c));
      if (c < 4) check("cont_ready3", 32'(req_ready[3]), 32'(c == 3));
      tick();
    end
    drain();

    // Fairness: FU0 streams (honouring ready), FU2 pushes once
    expect_bc(20, 16'h2000 + 20, 0);
    expect_bc(7,  16'h0707,      2);
    expect_bc(21, 16'h2000 + 21, 0);
    expect_bc(22, 16'h2000 + 22, 0);
    expect_bc(23, 16'h2000 + 23, 0);
    expect_bc(24, 16'h2000 + 24, 0);
    for (int c = 0; c < 6; c++) begin
      clear_req();
      set_req(0, int'(ft[c]), 16'h2000 + int'(ft[c]));
      if (c == 0) set_req(2, 7, 16'h0707);
      #1 check("fair_ready0", 32'(req_ready[0]), fr[c]);
      tick();
    end
    clear_req();
    drain();

    // Flush with FUs 0,1,3 pending; rr_ptr is 1 here
    set_req(0, 30, 16'h3030);
    set_req(1, 31, 16'h3131);
    set_req(3, 33, 16'h3333);
    tick();
    clear_req();
    flush = 1'b1;
    set_req(2, 32, 16'h3232);
    #1;
    check("flush_occ_before", 32'(occ), 3);
    check("flush_ready", 32'(req_ready), 0);
    tick();
    flush = 1'b0;
    clear_req();
    #1;
    check("flush_cdb_valid", 32'(cdb_valid), 0);
    check("flush_occ_after", 32'(occ), 0);
    for (int i = 0; i < 4; i++) set_req(i, 40 + i, 16'h4000 + 40 + i);
    expect_bc(41, 16'h4000 + 41, 1);
    expect_bc(42, 16'h4000 + 42, 2);
    expect_bc(43, 16'h4000 + 43, 3);
    expect_bc(40, 16'h4000 + 40, 0);
    tick();
    clear_req();
    drain();

    // Reset mid-operation: bring rr_ptr to 2 with three slots pending
    set_req(1, 50, 16'h5050);
    expect_bc(50, 16'h5050, 1);
    tick();
    clear_req();
    set_req(0, 60, 16'h6060);
    set_req(1, 61, 16'h6161);
    set_req(3, 63, 16'h6363);
    tick();
    clear_req();
    #1 check("mid_occ_before", 32'(occ), 3);
    reset = 1'b1;
    tick();
    check("mid_occ_after", 32'(occ), 0);
    check("mid_cdb_valid", 32'(cdb_valid), 0);
    reset = 1'b0;
    #1 check("mid_req_ready", 32'(req_ready), 32'hF);
    for (int i = 0; i < 4; i++) begin
      set_req(i, 70 + i, 16'h7000 + 70 + i);
      expect_bc(70 + i, 16'h7000 + 70 + i, i);
    end
    tick();
    clear_req();
    drain();

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
